// File: rtl/bp_nonsynth_commit_driver_pkg.sv
// Shared types for the nonsynth commit driver.
//   bp_commit_drv_state_e : replay state machine encoding
//   bp_commit_drv_rec_s   : one latched trace record (rec_* fields)
// The record struct is sized from the localparams below, which are also the
// default parameter values of bp_nonsynth_commit_driver.
package bp_nonsynth_commit_driver_pkg;

  localparam int unsigned vaddr_width_lp = 39;
  localparam int unsigned instr_width_lp = 32;
  localparam int unsigned dword_width_lp = 64;
  localparam int unsigned dpath_width_lp = 65;

  typedef enum logic [2:0] {
    e_idle     = 3'd0,
    e_req      = 3'd1,
    e_commit   = 3'd2,
    e_wb_wait  = 3'd3,
    e_cpl_wait = 3'd4
  } bp_commit_drv_state_e;

  typedef struct packed {
    logic [vaddr_width_lp-1:0] pc;
    logic [instr_width_lp-1:0] instr;
    logic                      ird_w_v;
    logic                      frd_w_v;
    logic                      req_v;
    logic                      trap_v;
    logic [dword_width_lp-1:0] cause;
    logic [dpath_width_lp-1:0] wdata;
  } bp_commit_drv_rec_s;

  // Destination register field of an RV instruction.
  function automatic logic [4:0] rec_rd(input logic [instr_width_lp-1:0] instr);
    return instr[11:7];
  endfunction

endpackage

// File: rtl/bp_commit_drv_delay.sv
// Loadable down-counter with a zero flag.
//   clk, reset_i (async, active-low)
//   load/load_val : load a new count (wins over dec)
//   dec           : decrement by one
//   zero          : count is zero
module bp_commit_drv_delay #(
  parameter int unsigned width_p = 4
) (
  input  logic               clk,
  input  logic               reset_i,
  input  logic               load,
  input  logic [width_p-1:0] load_val,
  input  logic               dec,
  output logic               zero
);

  logic [width_p-1:0] cnt;

  // Count register: load has priority, otherwise optional decrement.
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec) begin
      cnt <= cnt - width_p'(1);
    end else begin
      cnt <= cnt;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/bp_nonsynth_commit_driver.sv
// Nonsynth commit/writeback/cache-request stimulus source for the cosim
// commit checker. Pops one trace record at a time and replays it as
// optional blocking cache request -> commit/trap -> late writeback ->
// cache-request completion.
// Ports:
//   cosim_clk_i, reset_i (async, active-low)
//   en_i, wb_delay_i, cpl_delay_i      : accept enable and delay programming
//   rec_v_i/rec_ready_o, rec_*_i       : trace record stream
//   instret_o, trap_o, commit_*_o, cause_o        : commit pulse + payload
//   ird_w_v_o, frd_w_v_o, rd_addr_o, rd_data_o    : writeback pulse + payload
//   cache_req_yumi_o/blocking_o/complete_o        : cache request pulses
//   busy_o, instret_cnt_o, trap_cnt_o             : status and counters
module bp_nonsynth_commit_driver
  import bp_nonsynth_commit_driver_pkg::*;
#(
  parameter int unsigned vaddr_width_p = vaddr_width_lp,
  parameter int unsigned instr_width_p = instr_width_lp,
  parameter int unsigned dword_width_p = dword_width_lp,
  parameter int unsigned dpath_width_p = dpath_width_lp,
  parameter int unsigned delay_width_p = 4,
  parameter int unsigned cnt_width_p   = 32
) (
  input  logic                     cosim_clk_i,
  input  logic                     reset_i,
  input  logic                     en_i,
  input  logic [delay_width_p-1:0] wb_delay_i,
  input  logic [delay_width_p-1:0] cpl_delay_i,
  input  logic                     rec_v_i,
  output logic                     rec_ready_o,
  input  logic [vaddr_width_p-1:0] rec_pc_i,
  input  logic [instr_width_p-1:0] rec_instr_i,
  input  logic                     rec_ird_w_v_i,
  input  logic                     rec_frd_w_v_i,
  input  logic                     rec_req_v_i,
  input  logic                     rec_trap_v_i,
  input  logic [dword_width_p-1:0] rec_cause_i,
  input  logic [dpath_width_p-1:0] rec_wdata_i,
  output logic                     instret_o,
  output logic                     trap_o,
  output logic [vaddr_width_p-1:0] commit_pc_o,
  output logic [instr_width_p-1:0] commit_instr_o,
  output logic [dword_width_p-1:0] cause_o,
  output logic                     ird_w_v_o,
  output logic                     frd_w_v_o,
  output logic [4:0]               rd_addr_o,
  output logic [dpath_width_p-1:0] rd_data_o,
  output logic                     cache_req_yumi_o,
  output logic                     cache_req_blocking_o,
  output logic                     cache_req_complete_o,
  output logic                     busy_o,
  output logic [cnt_width_p-1:0]   instret_cnt_o,
  output logic [cnt_width_p-1:0]   trap_cnt_o
);

  bp_commit_drv_state_e state, state_n;
  bp_commit_drv_rec_s   rec;

  logic                     accept;
  logic                     ret_inc, trap_inc;
  logic                     dly_load, dly_dec, dly_zero;
  logic [delay_width_p-1:0] dly_val;

  // One counter serves both waits; they are never active at the same time.
  bp_commit_drv_delay #(.width_p(delay_width_p)) delay (
    .clk      (cosim_clk_i),
    .reset_i  (reset_i),
    .load     (dly_load),
    .load_val (dly_val),
    .dec      (dly_dec),
    .zero     (dly_zero)
  );

  // State, latched record and retire/trap counters.
  always_ff @(posedge cosim_clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state         <= e_idle;
      rec           <= '0;
      instret_cnt_o <= '0;
      trap_cnt_o    <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        rec <= '{pc: rec_pc_i, instr: rec_instr_i, ird_w_v: rec_ird_w_v_i,
                 frd_w_v: rec_frd_w_v_i, req_v: rec_req_v_i, trap_v: rec_trap_v_i,
                 cause: rec_cause_i, wdata: rec_wdata_i};
      end else begin
        rec <= rec;
      end
      instret_cnt_o <= instret_cnt_o + (ret_inc  ? cnt_width_p'(1) : cnt_width_p'(0));
      trap_cnt_o    <= trap_cnt_o    + (trap_inc ? cnt_width_p'(1) : cnt_width_p'(0));
    end
  end

  // Next state and per-state pulse/payload decode; payloads stay 0 unless
  // their valid is up.
  always_comb begin
    state_n              = state;
    accept               = 1'b0;
    ret_inc              = 1'b0;
    trap_inc             = 1'b0;
    dly_load             = 1'b0;
    dly_dec              = 1'b0;
    dly_val              = wb_delay_i;
    rec_ready_o          = 1'b0;
    instret_o            = 1'b0;
    trap_o               = 1'b0;
    commit_pc_o          = '0;
    commit_instr_o       = '0;
    cause_o              = '0;
    ird_w_v_o            = 1'b0;
    frd_w_v_o            = 1'b0;
    rd_addr_o            = 5'd0;
    rd_data_o            = '0;
    cache_req_yumi_o     = 1'b0;
    cache_req_blocking_o = 1'b0;
    cache_req_complete_o = 1'b0;
    busy_o               = (state != e_idle);

    case (state)
      e_idle: begin
        // reset_i gating keeps ready low while reset is held.
        rec_ready_o = en_i & reset_i;
        accept      = rec_v_i & rec_ready_o;
        if (accept) begin
          state_n = (rec_req_v_i & ~rec_trap_v_i) ? e_req : e_commit;
        end else begin
          state_n = e_idle;
        end
      end
      e_req: begin
        cache_req_yumi_o     = 1'b1;
        cache_req_blocking_o = 1'b1;
        state_n              = e_commit;
      end
      e_commit: begin
        instret_o      = ~rec.trap_v;
        trap_o         = rec.trap_v;
        commit_pc_o    = rec.pc;
        commit_instr_o = rec.instr;
        if (rec.trap_v) begin
          cause_o  = rec.cause;
          trap_inc = 1'b1;
          state_n  = e_idle;
        end else begin
          ret_inc = 1'b1;
          if (rec.ird_w_v | rec.frd_w_v) begin
            dly_load = 1'b1;
            dly_val  = wb_delay_i;
            state_n  = e_wb_wait;
          end else if (rec.req_v) begin
            dly_load = 1'b1;
            dly_val  = cpl_delay_i;
            state_n  = e_cpl_wait;
          end else begin
            state_n = e_idle;
          end
        end
      end
      e_wb_wait: begin
        if (dly_zero) begin
          ird_w_v_o = rec.ird_w_v;
          frd_w_v_o = rec.frd_w_v;
          rd_addr_o = rec_rd(rec.instr);
          rd_data_o = rec.wdata;
          if (rec.req_v) begin
            dly_load = 1'b1;
            dly_val  = cpl_delay_i;
            state_n  = e_cpl_wait;
          end else begin
            state_n = e_idle;
          end
        end else begin
          dly_dec = 1'b1;
        end
      end
      e_cpl_wait: begin
        if (dly_zero) begin
          cache_req_complete_o = 1'b1;
          state_n              = e_idle;
        end else begin
          dly_dec = 1'b1;
        end
      end
      default: begin
        state_n = e_idle;
      end
    endcase
  end

endmodule

// File: tb/tb_bp_nonsynth_commit_driver.sv
// Self-checking bench for bp_nonsynth_commit_driver: a table of directed
// records with hand-computed pulse cycles, plus enable, reset and
// back-to-back random sequences.
module tb_bp_nonsynth_commit_driver;

  logic         clk = 1'b0;
  logic         reset_i;
  logic         en_i;
  logic [3:0]   wb_delay_i, cpl_delay_i;
  logic         rec_v_i, rec_ready_o;
  logic [38:0]  rec_pc_i;
  logic [31:0]  rec_instr_i;
  logic         rec_ird_w_v_i, rec_frd_w_v_i, rec_req_v_i, rec_trap_v_i;
  logic [63:0]  rec_cause_i;
  logic [64:0]  rec_wdata_i;
  logic         instret_o, trap_o;
  logic [38:0]  commit_pc_o;
  logic [31:0]  commit_instr_o;
  logic [63:0]  cause_o;
  logic         ird_w_v_o, frd_w_v_o;
  logic [4:0]   rd_addr_o;
  logic [64:0]  rd_data_o;
  logic         cache_req_yumi_o, cache_req_blocking_o, cache_req_complete_o;
  logic         busy_o;
  logic [31:0]  instret_cnt_o, trap_cnt_o;

  int errors = 0;
  int checks = 0;
  int exp_instret = 0;
  int exp_trap = 0;

  always #5 clk = ~clk;

  bp_nonsynth_commit_driver dut (
    .cosim_clk_i(clk), .reset_i(reset_i), .en_i(en_i),
    .wb_delay_i(wb_delay_i), .cpl_delay_i(cpl_delay_i),
    .rec_v_i(rec_v_i), .rec_ready_o(rec_ready_o),
    .rec_pc_i(rec_pc_i), .rec_instr_i(rec_instr_i),
    .rec_ird_w_v_i(rec_ird_w_v_i), .rec_frd_w_v_i(rec_frd_w_v_i),
    .rec_req_v_i(rec_req_v_i), .rec_trap_v_i(rec_trap_v_i),
    .rec_cause_i(rec_cause_i), .rec_wdata_i(rec_wdata_i),
    .instret_o(instret_o), .trap_o(trap_o),
    .commit_pc_o(commit_pc_o), .commit_instr_o(commit_instr_o), .cause_o(cause_o),
    .ird_w_v_o(ird_w_v_o), .frd_w_v_o(frd_w_v_o),
    .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o),
    .cache_req_yumi_o(cache_req_yumi_o), .cache_req_blocking_o(cache_req_blocking_o),
    .cache_req_complete_o(cache_req_complete_o), .busy_o(busy_o),
    .instret_cnt_o(instret_cnt_o), .trap_cnt_o(trap_cnt_o)
  );

  // Directed record plus the hand-computed cycle (relative to the accept
  // cycle 0) of each pulse; -1 means the pulse must never appear.
  typedef struct {
    logic [38:0] pc;
    logic [31:0] instr;
    logic        ird, frd, req, trap;
    logic [63:0] cause;
    logic [64:0] wdata;
    logic [3:0]  wbd, cpld;
    int          k_yumi, k_commit, k_wb, k_cpl, k_idle;
  } vec_t;

  typedef struct {
    logic [38:0] pc;
    logic        trap;
  } exp_t;

  vec_t vecs[9];
  exp_t q[$];

  task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [319:0] all_outs();
    return {rec_ready_o, instret_o, trap_o, commit_pc_o, commit_instr_o, cause_o,
            ird_w_v_o, frd_w_v_o, rd_addr_o, rd_data_o, cache_req_yumi_o,
            cache_req_blocking_o, cache_req_complete_o, busy_o, instret_cnt_o, trap_cnt_o};
  endfunction

  function automatic vec_t mk(input logic [38:0] pc, input logic [31:0] instr,
                              input logic [3:0] flags, input logic [63:0] cause,
                              input logic [64:0] wdata, input logic [3:0] wbd, cpld,
                              input int ky, kc, kw, kp, ki);
    vec_t v;
    v.pc = pc; v.instr = instr;
    {v.ird, v.frd, v.req, v.trap} = flags;
    v.cause = cause; v.wdata = wdata; v.wbd = wbd; v.cpld = cpld;
    v.k_yumi = ky; v.k_commit = kc; v.k_wb = kw; v.k_cpl = kp; v.k_idle = ki;
    return v;
  endfunction

  task automatic drive_rec(input logic [38:0] pc, input logic [31:0] instr,
                           input logic [3:0] flags, input logic [63:0] cause,
                           input logic [64:0] wdata);
    rec_pc_i = pc; rec_instr_i = instr;
    {rec_ird_w_v_i, rec_frd_w_v_i, rec_req_v_i, rec_trap_v_i} = flags;
    rec_cause_i = cause; rec_wdata_i = wdata;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy_o && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("idle_timeout", {319'd0, busy_o}, 320'd0);
  endtask

  // Apply one table record and compare every cycle until it is back in IDLE.
  // Delay inputs are scrambled once their load has happened.
  task automatic run_vec(input vec_t v, input int idx);
    logic [7:0]   act, exp;
    logic [319:0] ecmt, edat;
    logic [4:0]   rd;
    wait_idle();
    @(negedge clk);
    drive_rec(v.pc, v.instr, {v.ird, v.frd, v.req, v.trap}, v.cause, v.wdata);
    wb_delay_i = v.wbd; cpl_delay_i = v.cpld; rec_v_i = 1'b1;
    #1;
    chk($sformatf("v%0d_accept_ready", idx), {319'd0, rec_ready_o}, {319'd0, 1'b1});
    for (int k = 1; k <= v.k_idle; k++) begin
      @(negedge clk);
      rec_v_i = 1'b0;
      if (k > v.k_commit) wb_delay_i = ~v.wbd;
      if (k > v.k_commit && k > v.k_wb) cpl_delay_i = ~v.cpld;
      #1;
      act = {rec_ready_o, busy_o, cache_req_yumi_o, cache_req_blocking_o, instret_o,
             trap_o, ird_w_v_o, frd_w_v_o};
      exp = {k == v.k_idle, k < v.k_idle, k == v.k_yumi, k == v.k_yumi,
             (k == v.k_commit) & ~v.trap, (k == v.k_commit) & v.trap,
             (k == v.k_wb) & v.ird, (k == v.k_wb) & v.frd};
      chk($sformatf("v%0d_k%0d_pulses", idx, k), {312'd0, act}, {312'd0, exp});
      chk($sformatf("v%0d_k%0d_cpl", idx, k), {319'd0, cache_req_complete_o},
          {319'd0, k == v.k_cpl});
      ecmt = '0;
      if (k == v.k_commit) ecmt = {185'd0, v.pc, v.instr, v.trap ? v.cause : 64'd0};
      chk($sformatf("v%0d_k%0d_commit_data", idx, k),
          {185'd0, commit_pc_o, commit_instr_o, cause_o}, ecmt);
      rd = v.instr[11:7];
      edat = '0;
      if (k == v.k_wb) edat = {250'd0, rd, v.wdata};
      chk($sformatf("v%0d_k%0d_wb_data", idx, k), {250'd0, rd_addr_o, rd_data_o}, edat);
    end
    if (v.trap) exp_trap++; else exp_instret++;
    chk($sformatf("v%0d_counts", idx), {256'd0, instret_cnt_o, trap_cnt_o},
        {256'd0, exp_instret[31:0], exp_trap[31:0]});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int accepted, commits, viol, cyc;
    logic took;
    logic [319:0] zero320;
    zero320 = '0;

    //                pc              instr        {ird,frd,req,trap} cause    wdata                 wbd   cpld  yumi com wb cpl idle
    vecs[0] = mk(39'h00_0000_1000, 32'h0000_0293, 4'b1000, 64'hFFFF, 65'h1234,               4'd0, 4'd0, -1, 1, 2, -1, 3);
    vecs[1] = mk(39'h00_0000_1004, 32'h0000_0503, 4'b1010, 64'h0,    65'hDEAD,               4'd3, 4'd2,  1, 2, 6,  9, 10);
    vecs[2] = mk(39'h00_0000_1008, 32'hFFFF_FFFF, 4'b1011, 64'h2,    65'h77,                 4'd1, 4'd1, -1, 1, -1, -1, 2);
    vecs[3] = mk(39'h00_0000_100C, 32'h00A1_2023, 4'b0010, 64'h0,    65'h0,                  4'd0, 4'd1,  1, 2, -1, 4, 5);
    vecs[4] = mk(39'h7F_FFFF_FFFC, 32'h0000_0187, 4'b0100, 64'h0,    65'h1_3FF0_0000_0000_0000, 4'd1, 4'd0, -1, 1, 3, -1, 4);
    vecs[5] = mk(39'h00_0000_1010, 32'h0000_0013, 4'b1010, 64'h0,    65'h55AA,               4'd0, 4'd0,  1, 2, 3,  4, 5);
    vecs[6] = mk(39'h00_0000_1014, 32'h0000_0393, 4'b1100, 64'h0,    65'h55,                 4'd2, 4'd0, -1, 1, 4, -1, 5);
    vecs[7] = mk(39'h00_0000_1018, 32'h0000_0073, 4'b0001, 64'hB,    65'h0,                  4'd0, 4'd0, -1, 1, -1, -1, 2);
    vecs[8] = mk(39'h00_0000_101C, 32'h0000_0F83, 4'b1010, 64'h0,    65'h1_FFFF_FFFF_FFFF_FFFF, 4'd15, 4'd15, 1, 2, 18, 34, 35);

    // Reset: every output 0 even with en_i and rec_v_i high.
    reset_i = 1'b0; en_i = 1'b1; rec_v_i = 1'b1; wb_delay_i = 4'd0; cpl_delay_i = 4'd0;
    drive_rec(39'h1, 32'h293, 4'b1000, 64'h0, 65'h1);
    #1;
    chk("reset_outputs", all_outs(), zero320);
    repeat (2) @(negedge clk);
    rec_v_i = 1'b0;
    reset_i = 1'b1;
    #1;

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // en_i low holds IDLE; raising it accepts in the same cycle.
    wait_idle();
    @(negedge clk);
    en_i = 1'b0; rec_v_i = 1'b1; wb_delay_i = 4'd0;
    drive_rec(39'h2000, 32'h0000_0293, 4'b0000, 64'h0, 65'h0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("en_low_hold", {318'd0, rec_ready_o, busy_o}, 320'd0);
      @(negedge clk);
    end
    en_i = 1'b1;
    #1;
    chk("en_rise_ready", {319'd0, rec_ready_o}, {319'd0, 1'b1});
    @(negedge clk);
    rec_v_i = 1'b0;
    #1;
    chk("en_rise_commit", {280'd0, instret_o, commit_pc_o}, {280'd0, 1'b1, 39'h2000});
    exp_instret++;
    wait_idle();

    // Reset during WB_WAIT drops the pending writeback.
    @(negedge clk);
    wb_delay_i = 4'd5; rec_v_i = 1'b1;
    drive_rec(39'h3000, 32'h0000_0293, 4'b1000, 64'h0, 65'hBEEF);
    @(negedge clk);
    rec_v_i = 1'b0;
    repeat (2) @(negedge clk);
    reset_i = 1'b0;
    #1;
    chk("midreset_outputs", all_outs(), zero320);
    exp_instret = 0; exp_trap = 0;
    @(negedge clk);
    reset_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      chk("midreset_no_wb", {317'd0, ird_w_v_o, frd_w_v_o, busy_o}, 320'd0);
    end
    run_vec(vecs[0], 100);

    // 100 back-to-back random records with rec_v_i held high.
    wait_idle();
    wb_delay_i = 4'd1; cpl_delay_i = 4'd2;
    accepted = 0; commits = 0; viol = 0; cyc = 0; took = 1'b1;
    while (commits < 100 && cyc < 20000) begin
      @(negedge clk);
      if (took) begin
        rec_v_i = (accepted < 100);
        drive_rec(39'h10_0000 + 39'(accepted * 4), $urandom,
                  {$urandom_range(1) == 1, $urandom_range(3) == 0,
                   $urandom_range(1) == 1, $urandom_range(3) == 0},
                  64'($urandom), 65'($urandom));
        took = 1'b0;
      end
      #1;
      if (rec_ready_o == busy_o) viol++;
      if (instret_o | trap_o) begin
        if (q.size() == 0) begin
          chk("order_empty", {319'd0, 1'b1}, 320'd0);
        end else begin
          chk("order_pc", {281'd0, commit_pc_o}, {281'd0, q[0].pc});
          chk("order_kind", {318'd0, instret_o, trap_o}, {318'd0, ~q[0].trap, q[0].trap});
          void'(q.pop_front());
        end
        commits++;
      end
      if (rec_v_i && rec_ready_o) begin
        q.push_back('{pc: rec_pc_i, trap: rec_trap_v_i});
        if (rec_trap_v_i) exp_trap++; else exp_instret++;
        accepted++;
        took = 1'b1;
      end
      cyc++;
    end
    rec_v_i = 1'b0;
    chk("rand_commits", 320'(commits), 320'd100);
    chk("rand_ready_only_idle", 320'(viol), 320'd0);
    wait_idle();
    chk("rand_counts", {256'd0, instret_cnt_o, trap_cnt_o},
        {256'd0, exp_instret[31:0], exp_trap[31:0]});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bp_nonsynth_commit_driver.md
Name: bp_nonsynth_commit_driver

Overview:
- Nonsynth stimulus source for the cosim commit checker; the transmitter end of the commit/writeback/cache-request interface that the checker consumes.
- Pops commit records from a valid/ready trace stream and replays each one as the timed pulse sequence that a real BE produces:
  - optional blocking cache request;
  - commit or trap;
  - late register writeback;
  - cache-request completion.
- Lets checker benches run without a full core.

Parameters:
vaddr_width_p, 39, commit PC width
instr_width_p, 32, instruction width
dword_width_p, 64, cause width
dpath_width_p, 65, writeback data width (integer data in low 64 bits, FP in dpath register format)
delay_width_p, 4, width of the programmable delay counters
cnt_width_p, 32, width of the retired/trap counters

Ports:
cosim_clk_i  in  1  clock
reset_i  in  1  reset
en_i  in  1  record accept enable; low holds IDLE
wb_delay_i  in  delay_width_p  cycles from commit pulse to writeback pulse
cpl_delay_i  in  delay_width_p  cycles from writeback (or commit) to completion pulse
rec_v_i  in  1  trace record valid
rec_ready_o  out  1  trace record ready
rec_pc_i  in  vaddr_width_p  record PC
rec_instr_i  in  instr_width_p  record instruction; rd = instr[11:7]
rec_ird_w_v_i  in  1  record writes integer RF
rec_frd_w_v_i  in  1  record writes FP RF
rec_req_v_i  in  1  record issues blocking cache request
rec_trap_v_i  in  1  record is a trap (no retire)
rec_cause_i  in  dword_width_p  trap cause
rec_wdata_i  in  dpath_width_p  writeback data
instret_o  out  1  commit pulse, retired
trap_o  out  1  commit pulse, exception
commit_pc_o  out  vaddr_width_p  committed PC
commit_instr_o  out  instr_width_p  committed instruction
cause_o  out  dword_width_p  cause, valid with trap_o
ird_w_v_o  out  1  integer writeback pulse
frd_w_v_o  out  1  FP writeback pulse
rd_addr_o  out  5  writeback address
rd_data_o  out  dpath_width_p  writeback data
cache_req_yumi_o  out  1  cache request accepted pulse
cache_req_blocking_o  out  1  asserted with yumi
cache_req_complete_o  out  1  completion pulse
busy_o  out  1  state != IDLE
instret_cnt_o  out  cnt_width_p  retired count
trap_cnt_o  out  cnt_width_p  trap count

Behaviour:
- Reset: asynchronous, active-low reset_i; clock cosim_clk_i.
  - While asserted: state=IDLE, every output 0, record register and counters cleared.
  - Reset mid-sequence drops the in-flight record; no pending pulses are emitted afterwards.
- State machine with states IDLE, REQ, COMMIT, WB_WAIT, CPL_WAIT.
- IDLE:
  - rec_ready_o = en_i.
  - On rec_v_i & rec_ready_o, latch the record. Next state is REQ if rec_req_v_i & ~rec_trap_v_i, else COMMIT.
- REQ: one cycle with cache_req_yumi_o=cache_req_blocking_o=1, then COMMIT.
- COMMIT: one cycle.
  - instret_o=~trap and trap_o=trap; PC, instr and cause are driven from the latched record.
  - If trap: trap_cnt++ and go to IDLE.
  - Else: instret_cnt++, then:
    - ird|frd set: go to WB_WAIT, counter loaded with wb_delay_i;
    - else req set: go to CPL_WAIT, counter loaded with cpl_delay_i;
    - else: go to IDLE.
- WB_WAIT:
  - Counter nonzero: decrement.
  - Counter zero: in that cycle pulse ird_w_v_o/frd_w_v_o per the record, with rd_addr_o=instr[11:7] and rd_data_o=wdata. Then go to CPL_WAIT (counter loaded with cpl_delay_i) if req, else IDLE.
  - wb_delay_i=0 gives the writeback exactly 1 cycle after the commit pulse.
- CPL_WAIT: same countdown. At zero, pulse cache_req_complete_o, then go to IDLE.
- Both ird and frd set in one record: both pulses fire in the same cycle (bench error case, passed through unchecked).
- rd=0 writebacks are still emitted; the consumer dequeues by rd.
- Delay inputs are sampled only at the counter load; later changes do not affect the running countdown.
- Counters wrap modulo 2^cnt_width_p.
- Only IDLE accepts a record, so per-record throughput is at least 2 cycles (IDLE, COMMIT).
- Data outputs are 0 whenever their valid is 0.

Decomposition:
- Shared nonsynth package holds:
  - the state enum bp_commit_drv_state_e;
  - a packed record struct bp_commit_drv_rec_s carrying the rec_* fields.
- One sub-module, bp_commit_drv_delay: loadable down-counter with a zero flag, instantiated once and shared by WB_WAIT and CPL_WAIT.

Test Plan:
- Plain ALU record, ird=1, rd=5, wdata=0x1234, wb_delay_i=0 -> instret_o at cycle t, ird_w_v_o with rd_addr_o=5 and data 0x1234 at t+1, instret_cnt_o=1, no cache pulses.
- Load record, req=1, ird=1, wb_delay_i=3, cpl_delay_i=2 -> yumi+blocking at t, instret at t+1, writeback at t+5, complete at t+8.
- Trap record, cause=0x2, req=1 -> no yumi; trap_o with cause_o=2 at t+1 after accept; trap_cnt_o=1; no writeback.
- Back-to-back 100 random records with rec_v_i held high -> rec_ready_o only in IDLE; counts match the generated record totals; commit order equals input order.
- Assert reset_i low during WB_WAIT -> all outputs 0 immediately; after release, no writeback pulse; the next record replays normally.
- en_i=0 with rec_v_i=1 -> rec_ready_o=0 and no activity; raising en_i accepts the record in the same cycle.
